lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Purpose: Load/store unit that turns one EX-stage memory op into a single data-memory transaction.
// Latency: accept to resp_valid is 2 cycles for stores and 3 for loads when grant and rvalid arrive immediately.
// Backpressure: req_ready is high only in IDLE, dmem_req is held until dmem_gnt, and WAIT times out after TIMEOUT_CYCLES.
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword and word accesses.
// If it is not defined, low address bits are cleared to reach natural alignment.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   req_valid / req_ready         op handshake from EX
//   MemRead, MemWrite, Funct3     op kind and size; MemWrite wins if both are set
//   ALUResult, StoreData, Rd      byte address, store data (rs2) and destination tag
//   resp_valid, ReadData,         one-cycle completion record
//   resp_rd, bus_error, misaligned
//   dmem_req/we/addr/be/wdata     data-memory request (word-aligned address)
//   dmem_gnt, dmem_rvalid,        data-memory grant and read return
//   dmem_rdata
module lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  input  logic [4:0]  Rd,
  output logic        resp_valid,
  output logic [31:0] ReadData,
  output logic [4:0]  resp_rd,
  output logic        bus_error,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic          op_store;
  logic [2:0]    op_f3;
  logic [1:0]    op_lane;
  logic          op_err;
  logic          op_mis;
  logic [CW-1:0] wait_cnt;

  // ---------------------------------------------------------------
  // Decode of the incoming op (only used on the accept cycle)
  // ---------------------------------------------------------------
  logic       accept;
  logic       legal;
  logic       sz_half;
  logic       sz_word;
  logic       trap_mis;
  logic [1:0] eff_lo;
  logic [3:0] be_next;
  logic [31:0] wdata_next;

  assign accept  = (state == IDLE) && req_valid && (MemRead || MemWrite);
  assign sz_half = (Funct3[1:0] == 2'b01);
  assign sz_word = (Funct3[1:0] == 2'b10);

  // Stores only know SB/SH/SW; loads add LBU/LHU.
  always_comb begin
    legal = 1'b0;
    if (MemWrite) begin
      case (Funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (Funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned legal ops are flagged and never reach the bus.
  always_comb begin
    eff_lo   = ALUResult[1:0];
    trap_mis = legal & ((sz_half & ALUResult[0]) |
                        (sz_word & (ALUResult[1:0] != 2'b00)));
  end
`else
  // Misaligned ops silently drop the offending low bits.
  always_comb begin
    trap_mis = 1'b0;
    if (sz_word)
      eff_lo = 2'b00;
    else if (sz_half)
      eff_lo = {ALUResult[1], 1'b0};
    else
      eff_lo = ALUResult[1:0];
  end
`endif

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << eff_lo;
        wdata_next = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_next    = eff_lo[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{StoreData[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = StoreData;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Load lane select and extension, driven from the registered op
  // ---------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  always_comb begin
    case (op_lane)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = op_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_f3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_ext = dmem_rdata;
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------
  // Illegal or trapped ops pass through REQ without touching the bus.
  assign req_ready  = (state == IDLE);
  assign dmem_req   = (state == REQ) && !op_err && !op_mis;
  assign resp_valid = (state == RESP);
  assign bus_error  = (state == RESP) && op_err;
  assign misaligned = (state == RESP) && op_mis;

  // ---------------------------------------------------------------
  // FSM and op registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_store   <= 1'b0;
      op_f3      <= 3'd0;
      op_lane    <= 2'd0;
      op_err     <= 1'b0;
      op_mis     <= 1'b0;
      wait_cnt   <= '0;
      ReadData   <= 32'd0;
      resp_rd    <= 5'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= REQ;
            op_store   <= MemWrite;
            op_f3      <= Funct3;
            op_lane    <= eff_lo;
            op_err     <= !legal;
            op_mis     <= trap_mis;
            resp_rd    <= Rd;
            ReadData   <= 32'd0;
            dmem_we    <= MemWrite;
            dmem_addr  <= {ALUResult[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= MemWrite ? wdata_next : 32'd0;
          end
        end
        REQ: begin
          wait_cnt <= '0;
          if (op_err || op_mis)
            state <= RESP;
          else if (dmem_gnt)
            state <= op_store ? RESP : WAIT;
        end
        WAIT: begin
          // A return on the final allowed cycle still counts as data.
          if (dmem_rvalid) begin
            ReadData <= load_ext;
            state    <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            op_err <= 1'b1;
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
